wb_stage_lsu: RTL and testbench

Parametrised writeback stage for the pipelined RISC-V core; successor to the fixed 32-bit, 4-way writeback.
- Registers the MEM-stage bundle and selects the register-file write value.
- Adds sub-word load extraction with sign/zero extension and variable-latency data-memory responses, stalling upstream until the load returns.
- Adds a flush input and a retired-instruction counter.

---
 rtl/core_pkg.sv | 17 +
 rtl/load_align.sv | 26 ++
 rtl/mux4to1.sv | 14 +
 rtl/wb_stage_lsu.sv | 111 +++++++++++
 tb/tb_wb_stage_lsu.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/core_pkg.sv
// core_pkg: shared writeback-stage types, result-source and load-size encodings
package core_pkg;
  typedef enum logic [1:0] {
    RES_ALU  = 2'b00,
    RES_LOAD = 2'b01,
    RES_PC4  = 2'b10,
    RES_IMM  = 2'b11
  } result_src_e;
  typedef enum logic [1:0] {IDLE, HOLD, WAIT} wb_state_e;
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LD  = 3'b011;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_LWU = 3'b110;
endpackage

// File: rtl/load_align.sv
// load_align: extracts a byte/half/word at a byte offset and sign/zero extends it
//   i_raw: raw read word, i_off: byte offset, i_funct3: load size/sign, o_data: extended value
module load_align
  import core_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int OFF_W = $clog2(XLEN / 8)
) (
  input  logic [XLEN-1:0]  i_raw,
  input  logic [OFF_W-1:0] i_off,
  input  logic [2:0]       i_funct3,
  output logic [XLEN-1:0]  o_data
);
  logic [XLEN-1:0] rot;
  // rotating the word puts the addressed byte in lane 0 and wraps misaligned upper lanes
  assign rot = XLEN'({i_raw, i_raw} >> {i_off, 3'b000});
  always_comb begin
    o_data = i_funct3 == F3_LB  ? XLEN'($signed(rot[7:0])) :
             i_funct3 == F3_LH  ? XLEN'($signed(rot[15:0])) :
             i_funct3 == F3_LW  ? XLEN'($signed(rot[31:0])) :
             i_funct3 == F3_LBU ? XLEN'(rot[7:0]) :
             i_funct3 == F3_LHU ? XLEN'(rot[15:0]) :
             (XLEN == 64 && i_funct3 == F3_LWU) ? XLEN'(rot[31:0]) :
             (XLEN == 64 && i_funct3 == F3_LD) ? rot : i_raw;
  end
endmodule

// File: rtl/mux4to1.sv
// mux4to1: W-bit 4:1 multiplexer
//   i_sel: select, i_d0..i_d3: data inputs, o_y: selected data
module mux4to1 #(
  parameter int W = 32
) (
  input  logic [1:0]   i_sel,
  input  logic [W-1:0] i_d0,
  input  logic [W-1:0] i_d1,
  input  logic [W-1:0] i_d2,
  input  logic [W-1:0] i_d3,
  output logic [W-1:0] o_y
);
  assign o_y = i_sel[1] ? (i_sel[0] ? i_d3 : i_d2) : (i_sel[0] ? i_d1 : i_d0);
endmodule

// File: rtl/wb_stage_lsu.sv
// wb_stage_lsu: writeback stage with variable-latency load return, flush and retire counter
//   i_*_MEM: MEM-stage bundle, i_mem_rvalid/i_mem_rdata: data-memory response, i_flush: kill held bundle
//   o_stall_WB: upstream hold, o_valid_WB/o_reg_write_WB/o_addr_des_WB/o_result_WB: writeback, o_retire_cnt: retired count
module wb_stage_lsu
  import core_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter int REG_ADDR_W     = 5,
  parameter int CNT_W          = 32,
  parameter bit ZERO_REG_GUARD = 1'b1
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_valid_MEM,
  input  logic                  i_flush,
  input  logic                  i_reg_write_MEM,
  input  logic [1:0]            i_result_src_MEM,
  input  logic [2:0]            i_funct3_MEM,
  input  logic [XLEN-1:0]       i_alu_result_MEM,
  input  logic [XLEN-1:0]       i_imm_MEM,
  input  logic [XLEN-1:0]       i_pc_plus4_MEM,
  input  logic [REG_ADDR_W-1:0] i_addr_des_MEM,
  input  logic                  i_mem_rvalid,
  input  logic [XLEN-1:0]       i_mem_rdata,
  output logic                  o_stall_WB,
  output logic                  o_valid_WB,
  output logic                  o_reg_write_WB,
  output logic [REG_ADDR_W-1:0] o_addr_des_WB,
  output logic [XLEN-1:0]       o_result_WB,
  output logic [CNT_W-1:0]      o_retire_cnt
);
  localparam int OFF_W = $clog2(XLEN / 8);
  wb_state_e              state_q, state_d;
  result_src_e            b_src_q, b_src_d;
  logic                   b_rw_q, b_rw_d;
  logic [2:0]             b_f3_q, b_f3_d;
  logic [OFF_W-1:0]       b_off_q, b_off_d;
  logic [REG_ADDR_W-1:0]  b_rd_q, b_rd_d;
  logic                   valid_q, valid_d, rw_q, rw_d;
  logic [REG_ADDR_W-1:0]  rd_q, rd_d;
  logic [XLEN-1:0]        res_q, res_d, load_data, mux_y;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   kill, cap, fire;
  assign kill    = i_flush && state_q != IDLE;
  assign cap     = !kill && state_q != WAIT;
  assign b_rw_d  = cap ? i_reg_write_MEM : b_rw_q;
  assign b_src_d = cap ? result_src_e'(i_result_src_MEM) : b_src_q;
  assign b_f3_d  = cap ? i_funct3_MEM : b_f3_q;
  assign b_off_d = cap ? i_alu_result_MEM[OFF_W-1:0] : b_off_q;
  assign b_rd_d  = cap ? i_addr_des_MEM : b_rd_q;
  load_align #(.XLEN(XLEN)) u_align (
    .i_raw   (i_mem_rdata),
    .i_off   (b_off_d),
    .i_funct3(b_f3_d),
    .o_data  (load_data)
  );
  // non-load sources are only selected on a capture edge, so the live inputs are the right operands
  mux4to1 #(.W(XLEN)) u_mux (
    .i_sel(b_src_d),
    .i_d0 (i_alu_result_MEM),
    .i_d1 (load_data),
    .i_d2 (i_pc_plus4_MEM),
    .i_d3 (i_imm_MEM),
    .o_y  (mux_y)
  );
  always_comb begin
    state_d = kill ? IDLE :
              !cap ? (i_mem_rvalid ? HOLD : WAIT) :
              !i_valid_MEM ? IDLE :
              (b_src_d != RES_LOAD || i_mem_rvalid) ? HOLD : WAIT;
    fire    = state_d == HOLD;
    valid_d = fire;
    rw_d    = fire && b_rw_d && !(ZERO_REG_GUARD && b_rd_d == '0);
    rd_d    = fire ? b_rd_d : rd_q;
    res_d   = fire ? mux_y : res_q;
    cnt_d   = cnt_q + CNT_W'(fire);
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      b_src_q <= RES_ALU;
      b_rw_q  <= 1'b0;
      b_f3_q  <= '0;
      b_off_q <= '0;
      b_rd_q  <= '0;
      valid_q <= 1'b0;
      rw_q    <= 1'b0;
      rd_q    <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      b_src_q <= b_src_d;
      b_rw_q  <= b_rw_d;
      b_f3_q  <= b_f3_d;
      b_off_q <= b_off_d;
      b_rd_q  <= b_rd_d;
      valid_q <= valid_d;
      rw_q    <= rw_d;
      rd_q    <= rd_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
    end
  end
  assign o_stall_WB     = state_q == WAIT;
  assign o_valid_WB     = valid_q;
  assign o_reg_write_WB = rw_q;
  assign o_addr_des_WB  = rd_q;
  assign o_result_WB    = res_q;
  assign o_retire_cnt   = cnt_q;
endmodule

// File: tb/tb_wb_stage_lsu.sv
// tb_wb_stage_lsu: directed and randomized checks of wb_stage_lsu against a behavioural model
module tb_wb_stage_lsu;
  logic        i_clk = 1'b0, i_rst_n = 1'b1;
  logic        i_valid_MEM = 1'b0, i_flush = 1'b0, i_reg_write_MEM = 1'b0, i_mem_rvalid = 1'b0;
  logic [1:0]  i_result_src_MEM = '0;
  logic [2:0]  i_funct3_MEM = '0;
  logic [31:0] i_alu_result_MEM = '0, i_imm_MEM = '0, i_pc_plus4_MEM = '0, i_mem_rdata = '0;
  logic [4:0]  i_addr_des_MEM = '0;
  logic        o_stall_WB, o_valid_WB, o_reg_write_WB;
  logic [4:0]  o_addr_des_WB;
  logic [31:0] o_result_WB, o_retire_cnt;
  int ntests = 0, nfail = 0;
  bit chk_en = 1'b0;
  bit          m_valid, m_rw, m_pend, p_rw;
  logic [4:0]  m_rd, p_rd;
  logic [31:0] m_res, m_cnt;
  logic [2:0]  p_f3;
  logic [1:0]  p_off;
  wb_stage_lsu dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid_MEM(i_valid_MEM), .i_flush(i_flush),
    .i_reg_write_MEM(i_reg_write_MEM), .i_result_src_MEM(i_result_src_MEM),
    .i_funct3_MEM(i_funct3_MEM), .i_alu_result_MEM(i_alu_result_MEM), .i_imm_MEM(i_imm_MEM),
    .i_pc_plus4_MEM(i_pc_plus4_MEM), .i_addr_des_MEM(i_addr_des_MEM),
    .i_mem_rvalid(i_mem_rvalid), .i_mem_rdata(i_mem_rdata), .o_stall_WB(o_stall_WB),
    .o_valid_WB(o_valid_WB), .o_reg_write_WB(o_reg_write_WB), .o_addr_des_WB(o_addr_des_WB),
    .o_result_WB(o_result_WB), .o_retire_cnt(o_retire_cnt)
  );
  always #5 i_clk = ~i_clk;
  function automatic logic [31:0] ld(logic [2:0] f3, logic [1:0] off, logic [31:0] w);
    int n;
    bit s;
    logic [63:0] v;
    case (f3)
      3'd0: begin n = 1; s = 1; end
      3'd1: begin n = 2; s = 1; end
      3'd2: begin n = 4; s = 1; end
      3'd4: begin n = 1; s = 0; end
      3'd5: begin n = 2; s = 0; end
      default: return w;
    endcase
    v = '0;
    for (int k = 0; k < n; k++)
      v |= 64'((w >> (8 * ((int'(off) + k) % 4))) & 32'hff) << (8 * k);
    if (s && v[8*n-1]) v |= ~((64'd1 << (8 * n)) - 64'd1);
    return v[31:0];
  endfunction
  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic emit(bit rw, logic [4:0] rd, logic [31:0] v);
    m_valid = 1; m_rw = rw && rd != 0; m_rd = rd; m_res = v; m_cnt = m_cnt + 1;
  endtask
  task automatic quiet();
    m_valid = 0; m_rw = 0;
  endtask
  task automatic m_reset();
    m_valid = 0; m_rw = 0; m_pend = 0; m_rd = 0; m_res = 0; m_cnt = 0;
  endtask
  task automatic step();
    if (!i_rst_n) m_reset();
    else if (m_pend) begin
      if (i_flush) begin m_pend = 0; quiet(); end
      else if (i_mem_rvalid) begin m_pend = 0; emit(p_rw, p_rd, ld(p_f3, p_off, i_mem_rdata)); end
      else quiet();
    end
    else if (i_flush && m_valid) quiet();
    else if (!i_valid_MEM) quiet();
    else if (i_result_src_MEM != 2'b01)
      emit(i_reg_write_MEM, i_addr_des_MEM,
           i_result_src_MEM == 2'b00 ? i_alu_result_MEM :
           i_result_src_MEM == 2'b10 ? i_pc_plus4_MEM : i_imm_MEM);
    else if (i_mem_rvalid)
      emit(i_reg_write_MEM, i_addr_des_MEM, ld(i_funct3_MEM, i_alu_result_MEM[1:0], i_mem_rdata));
    else begin
      m_pend = 1; p_rw = i_reg_write_MEM; p_rd = i_addr_des_MEM;
      p_f3 = i_funct3_MEM; p_off = i_alu_result_MEM[1:0]; quiet();
    end
  endtask
  always @(negedge i_clk) if (chk_en) begin
    chk("stall", o_stall_WB, m_pend);
    chk("valid", o_valid_WB, m_valid);
    chk("reg_write", o_reg_write_WB, m_rw);
    chk("rd", o_addr_des_WB, m_rd);
    chk("result", o_result_WB, m_res);
    chk("retire_cnt", o_retire_cnt, m_cnt);
  end
  task automatic cyc();
    @(posedge i_clk);
    step();
    #1;
  endtask
  task automatic idle_in();
    i_valid_MEM = 0; i_flush = 0; i_mem_rvalid = 0;
  endtask
  task automatic bundle(logic [1:0] src, logic [2:0] f3, logic [31:0] alu, logic [4:0] rd, bit rw);
    i_valid_MEM = 1; i_result_src_MEM = src; i_funct3_MEM = f3; i_alu_result_MEM = alu;
    i_addr_des_MEM = rd; i_reg_write_MEM = rw; i_imm_MEM = $urandom; i_pc_plus4_MEM = $urandom;
  endtask
  initial begin
    logic [2:0] f3s[8] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd3, 3'd6, 3'd7};
    m_reset();
    #1 i_rst_n = 0;
    chk_en = 1;
    cyc(); cyc();
    i_rst_n = 1;
    @(negedge i_clk);
    chk("rst_valid", o_valid_WB, 0);
    chk("rst_cnt", o_retire_cnt, 0);
    bundle(2'b00, 3'd0, 32'h0000_1234, 5'd5, 1);
    cyc(); idle_in();
    @(negedge i_clk);
    chk("alu_valid", o_valid_WB, 1);
    chk("alu_rw", o_reg_write_WB, 1);
    chk("alu_res", o_result_WB, 32'h0000_1234);
    chk("alu_cnt", o_retire_cnt, 1);
    bundle(2'b01, 3'd0, 32'h0000_0002, 5'd6, 1);
    i_mem_rvalid = 1; i_mem_rdata = 32'h0080_0000;
    cyc(); idle_in();
    @(negedge i_clk);
    chk("lb_sign", o_result_WB, 32'hFFFF_FF80);
    bundle(2'b01, 3'd4, 32'h0000_0002, 5'd6, 1);
    i_mem_rvalid = 1;
    cyc(); idle_in();
    @(negedge i_clk);
    chk("lbu_zero", o_result_WB, 32'h0000_0080);
    bundle(2'b01, 3'd1, 32'h0000_0003, 5'd9, 1);
    i_mem_rvalid = 1; i_mem_rdata = 32'h1122_3344;
    cyc(); idle_in();
    @(negedge i_clk);
    chk("lh_misaligned", o_result_WB, 32'h0000_4411);
    bundle(2'b01, 3'd2, 32'h0000_0001, 5'd9, 1);
    i_mem_rvalid = 1;
    cyc(); idle_in();
    @(negedge i_clk);
    chk("lw_misaligned", o_result_WB, 32'h4411_2233);
    bundle(2'b01, 3'd2, 32'h0000_0100, 5'd7, 1);
    i_mem_rdata = 32'h0BAD_0BAD;
    cyc();
    bundle(2'b00, 3'd0, 32'h0000_0055, 5'd8, 1);
    for (int i = 0; i < 3; i++) begin
      @(negedge i_clk);
      chk("lat3_stall", o_stall_WB, 1);
      chk("lat3_novalid", o_valid_WB, 0);
      #1;
      if (i == 2) begin i_mem_rvalid = 1; i_mem_rdata = 32'hDEAD_BEEF; end
      cyc();
    end
    i_mem_rvalid = 0;
    @(negedge i_clk);
    chk("lat3_res", o_result_WB, 32'hDEAD_BEEF);
    chk("lat3_rd", o_addr_des_WB, 7);
    chk("lat3_stall_low", o_stall_WB, 0);
    chk("lat3_cnt", o_retire_cnt, 6);
    cyc(); idle_in();
    @(negedge i_clk);
    chk("held_res", o_result_WB, 32'h0000_0055);
    chk("held_rd", o_addr_des_WB, 8);
    bundle(2'b01, 3'd2, 32'h0000_0000, 5'd11, 1);
    cyc(); idle_in();
    @(negedge i_clk);
    chk("flush_pre_stall", o_stall_WB, 1);
    #1 i_flush = 1; i_mem_rvalid = 1; i_mem_rdata = 32'h1357_9BDF;
    cyc(); idle_in();
    @(negedge i_clk);
    chk("flush_valid", o_valid_WB, 0);
    chk("flush_stall", o_stall_WB, 0);
    chk("flush_cnt", o_retire_cnt, 7);
    bundle(2'b00, 3'd0, 32'h0000_0077, 5'd0, 1);
    cyc(); idle_in();
    @(negedge i_clk);
    chk("x0_valid", o_valid_WB, 1);
    chk("x0_rw", o_reg_write_WB, 0);
    chk("x0_cnt", o_retire_cnt, 8);
    bundle(2'b01, 3'd2, 32'h0000_0000, 5'd10, 1);
    cyc(); idle_in();
    @(negedge i_clk);
    chk("rstw_stall", o_stall_WB, 1);
    #2 i_rst_n = 0;
    m_reset();
    cyc(); cyc();
    i_rst_n = 1; i_mem_rvalid = 1; i_mem_rdata = 32'hCAFE_F00D;
    cyc(); i_mem_rvalid = 0;
    @(negedge i_clk);
    chk("rstw_valid", o_valid_WB, 0);
    chk("rstw_rw", o_reg_write_WB, 0);
    chk("rstw_stall2", o_stall_WB, 0);
    chk("rstw_res", o_result_WB, 0);
    chk("rstw_cnt", o_retire_cnt, 0);
    #1;
    for (int i = 0; i < 3000; i++) begin
      if (!m_pend) begin
        bundle(2'($urandom), f3s[$urandom_range(0, 7)], $urandom,
               $urandom_range(0, 3) == 0 ? 5'd0 : 5'($urandom), 1'($urandom));
        i_valid_MEM = $urandom_range(0, 4) != 0;
      end
      i_flush = m_pend && $urandom_range(0, 9) == 0;
      i_mem_rvalid = $urandom_range(0, 2) == 0;
      i_mem_rdata = $urandom;
      cyc();
    end
    idle_in();
    cyc(); cyc();
    @(negedge i_clk);
    chk_en = 0;
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule
